// File: rtl/ioctl_router_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ioctl_router_pkg
// Description : Shared state encodings, download index codes, hardware
//               variant codes and the palette window helper for ioctl_router.
// Revision    : 1.0 - initial release
// ============================================================================
package ioctl_router_pkg;

  // Loader / core-reset sequencer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_HOLD = 2'd2,
    ST_RUN  = 2'd3
  } state_t;

  // HPS download stream indices
  localparam logic [7:0] IDX_ROM = 8'd0;
  localparam logic [7:0] IDX_HW  = 8'd1;
  localparam logic [7:0] IDX_DIP = 8'd254;

  // Hardware variant codes
  localparam logic [7:0] HW_UNKNOWN = 8'hFF;

  // True when addr falls inside the 32-byte window starting at base.
  // Compared one bit wider so a window near the top of the space cannot wrap.
  function automatic logic in_window(input logic [24:0] addr, input logic [24:0] base);
    return ({1'b0, addr} >= {1'b0, base}) &&
           ({1'b0, addr} <= ({1'b0, base} + 26'd31));
  endfunction

endpackage
`default_nettype wire

// File: rtl/ioctl_router_rst_stretch.sv
`default_nettype none
// ============================================================================
// Module      : rst_stretch
// Description : Loadable down-counter that stretches the core reset after a
//               ROM download; done is high whenever the count is zero.
// Revision    : 1.0 - initial release
// ============================================================================
module rst_stretch #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         count,
  output logic         done
);

  logic [W-1:0] cnt;

  // Load has priority; otherwise count down while enabled, saturating at zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (count && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == '0);

endmodule
`default_nettype wire

// File: rtl/ioctl_router.sv
`default_nettype none
// ============================================================================
// Module      : ioctl_router
// Description : Splits the HPS download stream into the game ROM write port,
//               palette PROM writes, DIP switch bytes and hardware type, and
//               holds the game core in reset around ROM downloads.
// Revision    : 1.0 - initial release
// ============================================================================
module ioctl_router
  import ioctl_router_pkg::*;
#(
  parameter logic [24:0] PAL_BASE   = 25'h018000,
  parameter int          RST_HOLD   = 16,
  parameter logic [7:0]  HW_DEFAULT = HW_UNKNOWN
) (
  input  logic        MCLK,
  input  logic        RESET,
  input  logic        DL,
  input  logic        WR,
  input  logic [24:0] ADDR,
  input  logic [7:0]  DIN,
  input  logic [7:0]  INDEX,
  output logic        ROMEN,
  output logic [24:0] ROMAD,
  output logic [7:0]  ROMDT,
  output logic        PALWR,
  output logic [4:0]  PALADR,
  output logic [7:0]  PALDAT,
  output logic [63:0] DIPS,
  output logic [7:0]  HWTYPE,
  output logic        CORE_RST,
  output logic        ROM_DL
);

  localparam logic [7:0] HOLD_INIT = 8'(RST_HOLD - 1);

  state_t state;
  state_t state_nxt;
  logic   dl_q;
  logic   rom_byte;
  logic   pal_hit;
  logic   hold_load;
  logic   hold_done;

  // The final strobe of a download may arrive together with DL dropping,
  // so a ROM write is still accepted while the sequencer sits in LOAD.
  assign rom_byte  = WR && (INDEX == IDX_ROM) && (DL || (state == ST_LOAD));
  assign pal_hit   = in_window(ADDR, PAL_BASE);
  assign hold_load = (state == ST_LOAD) && !DL;

  rst_stretch #(
    .W (8)
  ) u_rst_stretch (
    .clk      (MCLK),
    .rst      (RESET),
    .load     (hold_load),
    .load_val (HOLD_INIT),
    .count    (state == ST_HOLD),
    .done     (hold_done)
  );

  // State register plus DL history; history resets high so a DL already
  // asserted at reset release is not mistaken for a fresh download start
  always_ff @(posedge MCLK or posedge RESET) begin
    if (RESET) begin
      state <= ST_IDLE;
      dl_q  <= 1'b1;
    end else begin
      state <= state_nxt;
      dl_q  <= DL;
    end
  end

  // Next-state logic for the download / core-reset sequencer
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (DL && !dl_q && (INDEX == IDX_ROM)) state_nxt = ST_LOAD;
      ST_LOAD: if (!DL)                               state_nxt = ST_HOLD;
      ST_HOLD: begin
        if (DL && (INDEX == IDX_ROM)) state_nxt = ST_LOAD;
        else if (hold_done)           state_nxt = ST_RUN;
      end
      ST_RUN:  if (DL && (INDEX == IDX_ROM)) state_nxt = ST_LOAD;
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign CORE_RST = (state != ST_RUN);
  assign ROM_DL   = (state == ST_LOAD);

  // ROM and palette write ports: one-cycle registered pulses with data
  always_ff @(posedge MCLK or posedge RESET) begin
    if (RESET) begin
      ROMEN  <= 1'b0;
      ROMAD  <= '0;
      ROMDT  <= '0;
      PALWR  <= 1'b0;
      PALADR <= '0;
      PALDAT <= '0;
    end else begin
      ROMEN <= rom_byte;
      PALWR <= rom_byte && pal_hit;
      if (rom_byte) begin
        ROMAD <= ADDR;
        ROMDT <= DIN;
      end
      if (rom_byte && pal_hit) begin
        PALADR <= ADDR[4:0];
        PALDAT <= DIN;
      end
    end
  end

  // DIP switch bytes and hardware type captured from their own indices
  always_ff @(posedge MCLK or posedge RESET) begin
    if (RESET) begin
      DIPS   <= '0;
      HWTYPE <= HW_DEFAULT;
    end else begin
      if (WR && (INDEX == IDX_DIP) && (ADDR[24:3] == '0)) begin
        DIPS[{ADDR[2:0], 3'b000} +: 8] <= DIN;
      end
      if (WR && (INDEX == IDX_HW)) begin
        HWTYPE <= DIN;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ioctl_router.sv
`default_nettype none
// ============================================================================
// Module      : tb_ioctl_router
// Description : Self-checking bench for ioctl_router: directed scenarios and
//               a randomized phase compared cycle by cycle against a model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ioctl_router;

  // Palette window moved low so a full burst through it stays short
  localparam logic [24:0] PB   = 25'h0000A0;
  localparam int          HOLD = 16;
  localparam logic [7:0]  HWD  = 8'hFF;

  logic        MCLK  = 1'b0;
  logic        RESET = 1'b1;
  logic        DL    = 1'b0;
  logic        WR    = 1'b0;
  logic [24:0] ADDR  = '0;
  logic [7:0]  DIN   = '0;
  logic [7:0]  INDEX = '0;
  logic        ROMEN, PALWR, CORE_RST, ROM_DL;
  logic [24:0] ROMAD;
  logic [7:0]  ROMDT, PALDAT, HWTYPE;
  logic [4:0]  PALADR;
  logic [63:0] DIPS;

  int checks = 0;
  int errors = 0;

  // Reference model: "downloading", "core released" and cycles of reset left
  bit          m_loading, m_run, m_dlq;
  int          m_hold;
  logic        m_romen, m_palwr;
  logic [24:0] m_romad;
  logic [7:0]  m_romdt, m_paldat, m_hw;
  logic [4:0]  m_paladr;
  logic [7:0]  m_dips [8];

  int          rom_cnt, pal_cnt, n;
  logic [31:0] pal_mask;

  always #5 MCLK = ~MCLK;

  ioctl_router #(
    .PAL_BASE   (PB),
    .RST_HOLD   (HOLD),
    .HW_DEFAULT (HWD)
  ) dut (
    .MCLK     (MCLK),
    .RESET    (RESET),
    .DL       (DL),
    .WR       (WR),
    .ADDR     (ADDR),
    .DIN      (DIN),
    .INDEX    (INDEX),
    .ROMEN    (ROMEN),
    .ROMAD    (ROMAD),
    .ROMDT    (ROMDT),
    .PALWR    (PALWR),
    .PALADR   (PALADR),
    .PALDAT   (PALDAT),
    .DIPS     (DIPS),
    .HWTYPE   (HWTYPE),
    .CORE_RST (CORE_RST),
    .ROM_DL   (ROM_DL)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance the model by one clock edge using the inputs present at that edge
  task automatic model_update();
    bit rb;
    if (RESET) begin
      m_loading = 0; m_run = 0; m_hold = 0; m_dlq = 1;
      m_romen = 0; m_romad = '0; m_romdt = '0;
      m_palwr = 0; m_paladr = '0; m_paldat = '0;
      foreach (m_dips[i]) m_dips[i] = 8'h00;
      m_hw = HWD;
    end else begin
      rb = WR && (INDEX == 8'd0) && (DL || m_loading);
      m_romen = rb;
      if (rb) begin m_romad = ADDR; m_romdt = DIN; end
      m_palwr = rb && (ADDR >= PB) && (ADDR < PB + 32);
      if (m_palwr) begin m_paladr = 5'(ADDR % 32); m_paldat = DIN; end
      if (WR && INDEX == 8'd254 && ADDR < 8) m_dips[ADDR[2:0]] = DIN;
      if (WR && INDEX == 8'd1) m_hw = DIN;
      if (m_loading) begin
        if (!DL) begin m_loading = 0; m_hold = HOLD; end
      end else if (DL && INDEX == 8'd0 && (m_run || m_hold > 0 || !m_dlq)) begin
        m_loading = 1; m_hold = 0; m_run = 0;
      end else if (m_hold > 0) begin
        m_hold--;
        if (m_hold == 0) m_run = 1;
      end
      m_dlq = DL;
    end
  endtask

  task automatic check_outputs();
    logic [63:0] d;
    for (int i = 0; i < 8; i++) d[8*i +: 8] = m_dips[i];
    chk("ROMEN", ROMEN, m_romen);
    chk("ROMAD", ROMAD, m_romad);
    chk("ROMDT", ROMDT, m_romdt);
    chk("PALWR", PALWR, m_palwr);
    chk("PALADR", PALADR, m_paladr);
    chk("PALDAT", PALDAT, m_paldat);
    chk("DIPS", DIPS, d);
    chk("HWTYPE", HWTYPE, m_hw);
    chk("CORE_RST", CORE_RST, !m_run);
    chk("ROM_DL", ROM_DL, m_loading);
  endtask

  task automatic step(input logic dl_i, input logic wr_i, input logic [24:0] a,
                      input logic [7:0] d, input logic [7:0] idx);
    @(negedge MCLK);
    DL = dl_i; WR = wr_i; ADDR = a; DIN = d; INDEX = idx;
    @(posedge MCLK);
    model_update();
    #1;
    check_outputs();
    if (ROMEN) rom_cnt++;
    if (PALWR) begin pal_cnt++; pal_mask[PALADR] = 1'b1; end
  endtask

  // Idle until the core is released; returns the number of edges waited
  task automatic wait_release(output int cyc);
    cyc = 0;
    while (CORE_RST && cyc < 1000) begin
      step(0, 0, '0, 8'h00, 8'd0);
      cyc++;
    end
  endtask

  initial begin
    // Reset and quiet period after release
    repeat (3) step(0, 0, '0, 8'h00, 8'd0);
    chk("rst_core_rst", CORE_RST, 1'b1);
    chk("rst_hwtype", HWTYPE, 8'hFF);
    RESET = 1'b0;
    repeat (20) step(0, 0, '0, 8'h00, 8'd0);
    chk("idle_core_rst", CORE_RST, 1'b1);
    chk("idle_dips", DIPS, 64'h0);

    // DIP writes, one beyond the 8-byte range
    step(1, 1, 25'd2, 8'hA5, 8'd254);
    step(1, 1, 25'd8, 8'h11, 8'd254);
    step(0, 0, '0, 8'h00, 8'd0);
    chk("dips_a5", DIPS, 64'h0000_0000_00A5_0000);

    // Hardware type, last byte wins, core reset untouched
    step(1, 1, '0, 8'h03, 8'd1);
    step(1, 1, '0, 8'h05, 8'd1);
    step(0, 0, '0, 8'h00, 8'd0);
    chk("hwtype_05", HWTYPE, 8'h05);
    chk("hw_core_rst", CORE_RST, 1'b1);

    // Full ROM burst through the palette window
    rom_cnt = 0; pal_cnt = 0; pal_mask = '0;
    for (int a = 0; a <= int'(PB) + 32; a++) begin
      if ($urandom_range(0, 3) == 0) step(1, 0, 25'(a), 8'h00, 8'd0);
      step(1, 1, 25'(a), 8'($urandom), 8'd0);
    end
    step(0, 0, '0, 8'h00, 8'd0);
    wait_release(n);
    chk("burst_hold_len", n, HOLD);
    chk("burst_rom_cnt", rom_cnt, int'(PB) + 33);
    chk("burst_pal_cnt", pal_cnt, 32);
    chk("burst_pal_mask", pal_mask, 32'hFFFF_FFFF);

    // Download restarted 5 cycles into the reset hold
    step(1, 1, PB + 25'd3, 8'h5A, 8'd0);
    step(0, 0, '0, 8'h00, 8'd0);
    repeat (5) step(0, 0, '0, 8'h00, 8'd0);
    step(1, 0, '0, 8'h00, 8'd0);
    chk("rehold_rom_dl", ROM_DL, 1'b1);
    chk("rehold_core_rst", CORE_RST, 1'b1);
    step(1, 1, PB + 25'd7, 8'h77, 8'd0);
    // Last byte coincides with DL falling
    step(0, 1, PB + 25'd8, 8'h88, 8'd0);
    chk("lastbyte_romen", ROMEN, 1'b1);
    chk("lastbyte_paldat", PALDAT, 8'h88);
    wait_release(n);
    chk("rehold_hold_len", n, HOLD);

    // Addresses just outside the palette window must not alias into it
    step(1, 1, PB - 25'd1, 8'hC1, 8'd0);
    chk("oow_below", PALWR, 1'b0);
    step(1, 1, PB + 25'd32, 8'hC2, 8'd0);
    chk("oow_above", PALWR, 1'b0);
    step(1, 1, 25'h1FF_FFFF, 8'hC3, 8'd0);
    chk("oow_top", PALWR, 1'b0);
    chk("oow_top_romad", ROMAD, 25'h1FF_FFFF);
    step(1, 1, PB + 25'd67, 8'hC4, 8'd0);
    chk("oow_alias", PALWR, 1'b0);
    step(0, 0, '0, 8'h00, 8'd0);
    wait_release(n);
    chk("oow_hold_len", n, HOLD);

    // Randomized traffic against the model
    begin
      logic       rdl = 1'b0;
      logic [7:0] ridx;
      logic [24:0] ra;
      for (int i = 0; i < 800; i++) begin
        if ($urandom_range(0, 9) == 0) rdl = ~rdl;
        case ($urandom_range(0, 3))
          0: ridx = 8'd0;
          1: ridx = 8'd1;
          2: ridx = 8'd254;
          default: ridx = 8'($urandom_range(0, 255));
        endcase
        case ($urandom_range(0, 2))
          0: ra = PB - 25'd2 + 25'($urandom_range(0, 35));
          1: ra = 25'($urandom_range(0, 15));
          default: ra = 25'($urandom);
        endcase
        step(rdl, 1'($urandom_range(0, 1)), ra, 8'($urandom), ridx);
      end
    end

    // Reset in the middle of a download with DL held high
    step(0, 0, '0, 8'h00, 8'd0);
    step(0, 0, '0, 8'h00, 8'd0);
    step(1, 0, '0, 8'h00, 8'd0);
    chk("midload_rom_dl", ROM_DL, 1'b1);
    RESET = 1'b1;
    step(1, 1, 25'd5, 8'h99, 8'd0);
    step(1, 1, 25'd6, 8'h98, 8'd0);
    chk("midload_romen", ROMEN, 1'b0);
    chk("midload_rst_dl", ROM_DL, 1'b0);
    RESET = 1'b0;
    repeat (4) step(1, 0, '0, 8'h00, 8'd0);
    chk("held_dl_idle", ROM_DL, 1'b0);
    chk("held_dl_core_rst", CORE_RST, 1'b1);
    step(0, 0, '0, 8'h00, 8'd0);
    step(1, 0, '0, 8'h00, 8'd0);
    chk("fresh_rise_load", ROM_DL, 1'b1);
    step(0, 0, '0, 8'h00, 8'd0);
    wait_release(n);
    chk("final_hold_len", n, HOLD);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ioctl_router.md
IOCTL_ROUTER -- requirements
Module: ioctl_router

Interface
REQ-001 SHALL have parameter PAL_BASE, default 25'h018000, meaning the byte address of the 32-byte palette window in the index-0 stream.
REQ-002 SHALL have parameter RST_HOLD, default 16, meaning the number of MCLK cycles CORE_RST stays high after an index-0 download ends (range 1..255).
REQ-003 SHALL have parameter HW_DEFAULT, default 8'hFF, meaning the HWTYPE value when no index-1 byte has been received.
REQ-004 SHALL have port MCLK, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port RESET, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have inputs DL (1 bit, download active), WR (1 bit, byte strobe), ADDR (25 bits), DIN (8 bits) and INDEX (8 bits), carrying the HPS download stream.
REQ-007 SHALL have outputs ROMEN (1 bit), ROMAD (25 bits) and ROMDT (8 bits): the game ROM write port.
REQ-008 SHALL have outputs PALWR (1 bit), PALADR (5 bits) and PALDAT (8 bits): the palette PROM write port.
REQ-009 SHALL have output DIPS, 64 bits: DIP bytes 0..7, with byte n at bits [8n+7:8n].
REQ-010 SHALL have output HWTYPE, 8 bits: the hardware variant code.
REQ-011 SHALL have output CORE_RST, 1 bit: the reset request to the game core.
REQ-012 SHALL have output ROM_DL, 1 bit: high while an index-0 download is in progress.

Function
REQ-013 SHALL qualify a write as "rom byte" when WR=1, DL=1 and INDEX=0.
REQ-014 SHALL register each rom byte onto ROMEN/ROMAD/ROMDT with exactly 1-cycle latency; ROMEN is a single-cycle pulse per byte.
REQ-015 SHALL, when a rom byte's ADDR lies in PAL_BASE..PAL_BASE+31, also pulse PALWR in the same cycle as ROMEN, with PALADR=ADDR[4:0] and PALDAT=DIN.
REQ-016 SHALL write DIN into DIPS byte ADDR[2:0] on WR=1 with INDEX=254 and ADDR[24:3]=0; writes at higher addresses are ignored.
REQ-017 SHALL load HWTYPE from DIN on every WR=1 with INDEX=1; the last such byte wins.
REQ-018 SHALL implement an FSM with four states:
  - IDLE: entered from reset; moves to LOAD when DL=1 and INDEX=0.
  - LOAD: ROM_DL=1; moves to HOLD when DL falls.
  - HOLD: counter runs from RST_HOLD-1 down to 0; moves to RUN at count 0.
  - RUN: moves to LOAD when DL=1 and INDEX=0.
REQ-019 SHALL drive CORE_RST=1 in IDLE, LOAD and HOLD, and CORE_RST=0 only in RUN.
REQ-020 SHALL keep the FSM unaffected by downloads with INDEX other than 0; they never assert CORE_RST.
REQ-021 SHALL handle a new index-0 DL rising during HOLD by returning to LOAD and reloading the counter on the next HOLD entry.
REQ-022 SHALL treat a WR in the same cycle as a DL fall as a valid byte; the state still advances to HOLD.
REQ-023 SHALL let ADDR values outside the palette window reach the ROM port only, with no wrap into PALADR.

Reset
REQ-024 SHALL, while RESET=1, force: state IDLE, counter 0, ROMEN=0, PALWR=0, ROMAD=0, ROMDT=0, PALADR=0, PALDAT=0, DIPS=0, HWTYPE=HW_DEFAULT, CORE_RST=1, ROM_DL=0.
REQ-025 SHALL, on RESET asserted mid-LOAD, abort the download state; after release, the FSM waits in IDLE for a fresh DL rise with INDEX=0.

Structure
REQ-026 SHALL take FSM state encodings and the HW_* variant codes from the shared package (defs), not from local literals.
REQ-027 SHALL place the hold counter in one sub-module named rst_stretch (load, count, done); all other logic is flat.

Verification
REQ-028 Reset release with no stimulus -> CORE_RST=1, HWTYPE=8'hFF, DIPS=0 indefinitely.
REQ-029 Index-0 burst at 0x00000..0x18020 ending with DL fall -> ROMEN count=0x18021, PALWR count=32 with PALADR 0..31, CORE_RST falls exactly RST_HOLD cycles after DL falls.
REQ-030 Index-254 writes of 0xA5 at ADDR 2 and 0x11 at ADDR 8 -> DIPS[23:16]=0xA5, every other byte 0.
REQ-031 Index-1 writes of 0x03 then 0x05 -> HWTYPE=0x05; CORE_RST unchanged throughout.
REQ-032 DL rising again 5 cycles into HOLD -> ROM_DL=1 next cycle, CORE_RST stays 1 with no glitch, full RST_HOLD counted after the second DL fall.
REQ-033 RESET pulsed mid-LOAD with DL held high -> returns to IDLE, ROMEN=0, and re-enters LOAD only after DL is deasserted and re-raised.
